// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared prescaler and one
// shared period counter. The counter runs edge-aligned (0..P, wrap) or
// centre-aligned (0..P..1, then 0). Each channel has a pending duty register
// that is copied to its active register only at a period boundary, plus its
// own output polarity.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   en           run enable; while low, the counters are held and the shadows load
//   center       0 = edge-aligned, 1 = centre-aligned (shadowed)
//   period       counter top value (shadowed)
//   prescale     a counter tick occurs every prescale+1 clocks
//   duty_wr      one-cycle duty write strobe
//   duty_sel     channel index for the write (ignored if >= CHANNELS)
//   duty_data    duty value for the write
//   pol          per-channel polarity, 1 inverts (not shadowed)
//   pwm_out      registered PWM outputs
//   period_tick  one-clock pulse while cnt sits at 0 after a boundary
module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESC_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                center,
  input  logic [WIDTH-1:0]    period,
  input  logic [PRESC_W-1:0]  prescale,
  input  logic                duty_wr,
  input  logic [3:0]          duty_sel,
  input  logic [WIDTH-1:0]    duty_data,
  input  logic [CHANNELS-1:0] pol,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  localparam logic [WIDTH-1:0]   CNT_ONE  = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PCNT_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  dir_e                dir_q, dir_d;
  logic [WIDTH-1:0]    duty_pend_q [CHANNELS];
  logic [WIDTH-1:0]    duty_pend_d [CHANNELS];
  logic [WIDTH-1:0]    duty_act_q  [CHANNELS];
  logic [WIDTH-1:0]    duty_act_d  [CHANNELS];
  logic [WIDTH-1:0]    period_act_q, period_act_d;
  logic                center_act_q, center_act_d;
  logic [CHANNELS-1:0] pwm_out_q, pwm_out_d;
  logic                period_tick_q, period_tick_d;

  logic                tick;
  logic                boundary;
  logic [WIDTH-1:0]    cnt_step;
  dir_e                dir_step;

  // Counter value and direction that one tick would produce.
  always_comb begin
    cnt_step = cnt_q;
    dir_step = dir_q;
    if (!center_act_q) begin
      dir_step = DIR_UP;
      cnt_step = (cnt_q == period_act_q) ? '0 : cnt_q + CNT_ONE;
    end else if (period_act_q == '0) begin
      // Degenerate centre period: cnt pinned at 0, every tick is a boundary.
      dir_step = DIR_UP;
      cnt_step = '0;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == period_act_q) begin
        dir_step = DIR_DOWN;
        cnt_step = period_act_q - CNT_ONE;
      end else begin
        cnt_step = cnt_q + CNT_ONE;
      end
    end else begin
      if (cnt_q == '0) begin
        dir_step = DIR_UP;
        cnt_step = CNT_ONE;
      end else begin
        cnt_step = cnt_q - CNT_ONE;
      end
    end
  end

  always_comb begin
    pcnt_d        = pcnt_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    duty_pend_d   = duty_pend_q;
    duty_act_d    = duty_act_q;
    period_act_d  = period_act_q;
    center_act_d  = center_act_q;
    pwm_out_d     = pwm_out_q;
    period_tick_d = 1'b0;
    boundary      = 1'b0;
    tick          = en && (pcnt_q == prescale);

    // Writes land in the pending bank only; the active bank reads the old
    // pending value if a write coincides with a boundary.
    for (int i = 0; i < CHANNELS; i++) begin
      if (duty_wr && (duty_sel == 4'(i))) begin
        duty_pend_d[i] = duty_data;
      end
    end

    if (!en) begin
      pcnt_d       = '0;
      cnt_d        = '0;
      dir_d        = DIR_UP;
      period_act_d = period;
      center_act_d = center;
      duty_act_d   = duty_pend_q;
      pwm_out_d    = pol;
    end else begin
      pcnt_d = tick ? '0 : pcnt_q + PCNT_ONE;
      if (tick) begin
        cnt_d    = cnt_step;
        dir_d    = dir_step;
        boundary = (cnt_step == '0);
        if (boundary) begin
          duty_act_d   = duty_pend_q;
          period_act_d = period;
          center_act_d = center;
          if (center != center_act_q) begin
            dir_d = DIR_UP;
          end
        end
      end
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out_d[i] = pol[i] ^ (cnt_q < duty_act_q[i]);
      end
      period_tick_d = boundary;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q        <= '0;
      cnt_q         <= '0;
      dir_q         <= DIR_UP;
      period_act_q  <= '0;
      center_act_q  <= 1'b0;
      pwm_out_q     <= '0;
      period_tick_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_pend_q[i] <= '0;
        duty_act_q[i]  <= '0;
      end
    end else begin
      pcnt_q        <= pcnt_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      period_act_q  <= period_act_d;
      center_act_q  <= center_act_d;
      pwm_out_q     <= pwm_out_d;
      period_tick_q <= period_tick_d;
      duty_pend_q   <= duty_pend_d;
      duty_act_q    <= duty_act_d;
    end
  end

  assign pwm_out     = pwm_out_q;
  assign period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a reference model pushes the expected outputs for every
// clock into a queue and a separate monitor pops and compares them; directed
// windows additionally count high clocks and period ticks.
module tb_pwm_multi;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          center = 1'b0;
  logic [W-1:0]  period = '0;
  logic [PW-1:0] prescale = '0;
  logic          duty_wr = 1'b0;
  logic [3:0]    duty_sel = '0;
  logic [W-1:0]  duty_data = '0;
  logic [CH-1:0] pol = '0;
  logic [CH-1:0] pwm_out;
  logic          period_tick;

  pwm_multi #(.CHANNELS(CH), .WIDTH(W), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .center(center), .period(period),
    .prescale(prescale), .duty_wr(duty_wr), .duty_sel(duty_sel),
    .duty_data(duty_data), .pol(pol), .pwm_out(pwm_out),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position k within the current period, in ticks.
  typedef struct packed {
    logic [CH-1:0] out;
    logic          tick;
  } exp_t;

  exp_t       sb[$];
  int         m_pend[CH];
  int         m_act[CH];
  int         m_pact;
  bit         m_cact;
  logic [7:0] m_ph;
  int         m_k;

  function automatic int period_len();
    if (!m_cact) return m_pact + 1;
    if (m_pact == 0) return 1;
    return 2 * m_pact;
  endfunction

  function automatic int cnt_now();
    if (m_cact && m_k > m_pact) return 2 * m_pact - m_k;
    return m_k;
  endfunction

  task automatic model_step();
    exp_t e;
    int   old_pend[CH];
    int   c;
    int   sel;
    bit   tk;
    bit   bnd;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin m_pend[i] = 0; m_act[i] = 0; end
      m_pact = 0; m_cact = 0; m_ph = 0; m_k = 0;
      sb.delete();
    end else begin
      old_pend = m_pend;
      sel = int'(duty_sel);
      if (duty_wr && sel < CH) m_pend[sel] = int'(duty_data);
      e.tick = 1'b0;
      if (!en) begin
        e.out  = pol;
        m_act  = old_pend;
        m_pact = int'(period);
        m_cact = center;
        m_ph   = 0;
        m_k    = 0;
      end else begin
        c = cnt_now();
        for (int i = 0; i < CH; i++) e.out[i] = pol[i] ^ (c < m_act[i]);
        tk   = (m_ph == prescale);
        m_ph = tk ? 8'd0 : m_ph + 8'd1;
        bnd  = 1'b0;
        if (tk) begin
          m_k++;
          if (m_k >= period_len()) begin m_k = 0; bnd = 1'b1; end
        end
        e.tick = bnd;
        if (bnd) begin
          m_act  = old_pend;
          m_pact = int'(period);
          m_cact = center;
        end
      end
      sb.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Monitor: the DUT presents a new output every clock.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_pwm_out", int'(pwm_out), int'(e.out));
      check("sb_period_tick", int'(period_tick), int'(e.tick));
    end
  end

  int win_hi[CH];
  int win_tk;

  task automatic count_win(input int n);
    for (int i = 0; i < CH; i++) win_hi[i] = 0;
    win_tk = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) if (pwm_out[i]) win_hi[i]++;
      if (period_tick) win_tk++;
    end
  endtask

  task automatic write_duty(input int sel, input int data);
    duty_wr   = 1'b1;
    duty_sel  = 4'(sel);
    duty_data = 8'(data);
    @(negedge clk);
    duty_wr   = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (period_tick !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_period_tick", int'(period_tick === 1'b1), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset mid-run: duty 5 everywhere, polarity mix keeps outputs nonzero.
    period = 8'd9; prescale = '0; center = 1'b0; pol = 4'b0011;
    for (int ch = 0; ch < CH; ch++) write_duty(ch, 5);
    en = 1'b1;
    repeat (15) @(negedge clk);
    #2;
    rst = 1'b1;
    pol = '0;
    #1;
    check("async_rst_pwm_out", int'(pwm_out), 0);
    check("async_rst_tick", int'(period_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    count_win(20);
    for (int i = 0; i < CH; i++) check("post_rst_out_low", win_hi[i], 0);

    // Edge mode and duty limits.
    en = 1'b0;
    write_duty(0, 3);
    write_duty(1, 0);
    write_duty(2, 10);
    write_duty(3, 255);
    en = 1'b1;
    wait_tick();
    count_win(20);
    check("edge_ch0_high", win_hi[0], 6);
    check("edge_ch1_zero", win_hi[1], 0);
    check("edge_ch2_full", win_hi[2], 20);
    check("edge_ch3_full", win_hi[3], 20);
    check("edge_ticks", win_tk, 2);
    pol = 4'b0100;
    repeat (2) @(negedge clk);
    count_win(20);
    check("pol2_inverted", win_hi[2], 0);
    pol = '0;

    // Shadowing: write at cnt=4, ignored write, write coinciding with boundary.
    wait_tick();
    repeat (4) @(negedge clk);
    write_duty(1, 5);
    write_duty(9, 0);
    repeat (3) @(negedge clk);
    write_duty(1, 7);
    check("boundary_tick", int'(period_tick), 1);
    count_win(10);
    check("shadow_first_5", win_hi[1], 5);
    count_win(10);
    check("shadow_then_7", win_hi[1], 7);
    count_win(10);
    check("shadow_still_7", win_hi[1], 7);

    // Centre mode: prescale 1, period 4, duty 2.
    en = 1'b0;
    center = 1'b1; prescale = 8'd1; period = 8'd4;
    write_duty(0, 2);
    en = 1'b1;
    wait_tick();
    count_win(32);
    check("centre_ch0_high", win_hi[0], 12);
    check("centre_ticks", win_tk, 2);

    // Enable control.
    wait_tick();
    repeat (5) @(negedge clk);
    en = 1'b0;
    pol = 4'b1010;
    @(negedge clk);
    check("en_low_out_pol", int'(pwm_out), 10);
    check("en_low_no_tick", int'(period_tick), 0);
    period = 8'd3; center = 1'b0; prescale = '0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    wait_tick();
    count_win(8);
    check("new_period_ticks", win_tk, 2);

    // Randomised segments checked by the scoreboard.
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      en = 1'b0;
      center = 1'($urandom_range(0, 1));
      period = 8'($urandom_range(0, 12));
      prescale = 8'($urandom_range(0, 3));
      pol = 4'($urandom);
      repeat (2) @(negedge clk);
      en = 1'b1;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        duty_wr   = ($urandom_range(0, 5) == 0);
        duty_sel  = 4'($urandom_range(0, 9));
        duty_data = 8'($urandom_range(0, 14));
        if ($urandom_range(0, 39) == 0) pol = 4'($urandom);
        if ($urandom_range(0, 59) == 0) period = 8'($urandom_range(0, 12));
        if ($urandom_range(0, 79) == 0) center = ~center;
        if ($urandom_range(0, 99) == 0) en = ~en;
      end
      duty_wr = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
